// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with valid/ready handshake, flush and write-back select.
// Optional one-entry skid buffer enabled by defining MEM_WB_SKID_EN; state updates on falling clock edge.
module mem_wb_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     DataOutDataMemory_in,
  input  logic [DATA_W-1:0]     ALUResult_in,
  input  logic                  memToReg_in,
  input  logic                  regWrite_in,
  input  logic [REG_ADDR_W-1:0] writeReg_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     DataOutDataMemory,
  output logic [DATA_W-1:0]     ALUResult,
  output logic                  memToReg,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0]     writeData
);

  logic                  out_valid_reg;
  logic [DATA_W-1:0]     mem_data_reg;
  logic [DATA_W-1:0]     alu_result_reg;
  logic                  mem_to_reg_reg;
  logic                  reg_write_reg;
  logic [REG_ADDR_W-1:0] write_reg_reg;

  logic accept;
  logic out_load;

  assign accept   = in_valid & in_ready;
  assign out_load = !out_valid_reg | out_ready;

`ifdef MEM_WB_SKID_EN
  logic                  skid_valid_reg;
  logic [DATA_W-1:0]     skid_mem_data_reg;
  logic [DATA_W-1:0]     skid_alu_result_reg;
  logic                  skid_mem_to_reg_reg;
  logic                  skid_reg_write_reg;
  logic [REG_ADDR_W-1:0] skid_write_reg_reg;

  // Registered ready: the upstream stage never sees a combinational path from out_ready.
  assign in_ready = !skid_valid_reg;

  always_ff @(negedge clock) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      write_reg_reg  <= '0;
      mem_data_reg   <= '0;
      alu_result_reg <= '0;
      skid_valid_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (out_load) begin
      if (skid_valid_reg) begin
        // Skid entry is older than anything upstream, so it drains first.
        out_valid_reg  <= 1'b1;
        mem_data_reg   <= skid_mem_data_reg;
        alu_result_reg <= skid_alu_result_reg;
        mem_to_reg_reg <= skid_mem_to_reg_reg;
        reg_write_reg  <= skid_reg_write_reg;
        write_reg_reg  <= skid_write_reg_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= accept;
        reg_write_reg <= accept & regWrite_in;
        if (accept) begin
          mem_data_reg   <= DataOutDataMemory_in;
          alu_result_reg <= ALUResult_in;
          mem_to_reg_reg <= memToReg_in;
          write_reg_reg  <= writeReg_in;
        end
      end
    end else if (accept) begin
      skid_valid_reg      <= 1'b1;
      skid_mem_data_reg   <= DataOutDataMemory_in;
      skid_alu_result_reg <= ALUResult_in;
      skid_mem_to_reg_reg <= memToReg_in;
      skid_reg_write_reg  <= regWrite_in;
      skid_write_reg_reg  <= writeReg_in;
    end
  end
`else
  assign in_ready = out_load;

  always_ff @(negedge clock) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      write_reg_reg  <= '0;
      mem_data_reg   <= '0;
      alu_result_reg <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      reg_write_reg <= 1'b0;
    end else if (out_load) begin
      out_valid_reg <= accept;
      reg_write_reg <= accept & regWrite_in;
      if (accept) begin
        mem_data_reg   <= DataOutDataMemory_in;
        alu_result_reg <= ALUResult_in;
        mem_to_reg_reg <= memToReg_in;
        write_reg_reg  <= writeReg_in;
      end
    end
  end
`endif

  assign out_valid         = out_valid_reg;
  assign DataOutDataMemory = mem_data_reg;
  assign ALUResult         = alu_result_reg;
  assign memToReg          = mem_to_reg_reg;
  assign regWrite          = reg_write_reg;
  assign writeReg          = write_reg_reg;
  assign writeData         = mem_to_reg_reg ? mem_data_reg : alu_result_reg;

endmodule
